// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-beat RAM port between two masters.
// At most one read is outstanding; a read that never returns is aborted by a timeout.
module ram_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 16,
    parameter int READ_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic              req0_wr_en,
    input  logic              req0_rd_en,
    input  logic [DATA_W-1:0] req0_data_write,
    output logic              req0_ready,
    output logic [DATA_W-1:0] req0_data_read,
    output logic              req0_data_read_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic              req1_wr_en,
    input  logic              req1_rd_en,
    input  logic [DATA_W-1:0] req1_data_write,
    output logic              req1_ready,
    output logic [DATA_W-1:0] req1_data_read,
    output logic              req1_data_read_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [DATA_W-1:0] mem_data_write,
    input  logic [DATA_W-1:0] mem_data_read,
    input  logic              mem_data_read_valid,
    output logic              err_timeout,
    output logic              err_sticky
);
    localparam int CNT_W = (READ_TIMEOUT < 2) ? 1 : $clog2(READ_TIMEOUT);
    // Counter is 0 in the first WAIT_READ cycle, so the abort decision is
    // taken when it holds READ_TIMEOUT-1 and becomes visible one cycle later.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_TIMEOUT - 1);

    typedef enum logic {IDLE, WAIT_READ} state_t;

    state_t             state_reg, state_next;
    logic               last_grant_reg;
    logic               owner_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic               req0, req1;
    logic               grant0, grant1, grant_any;
    logic               sel_wr, sel_rd, sel_read;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               read_done, read_abort;

    assign req0 = req0_wr_en | req0_rd_en;
    assign req1 = req1_wr_en | req1_rd_en;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_reg == IDLE) begin
            if (req0 && req1) begin
                grant0 = last_grant_reg;
                grant1 = ~last_grant_reg;
            end else begin
                grant0 = req0;
                grant1 = req1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign grant_any  = grant0 | grant1;
    assign sel_wr     = grant1 ? req1_wr_en      : req0_wr_en;
    assign sel_rd     = grant1 ? req1_rd_en      : req0_rd_en;
    assign sel_addr   = grant1 ? req1_addr       : req0_addr;
    assign sel_data   = grant1 ? req1_data_write : req0_data_write;
    // A command with both enables high is treated as a write.
    assign sel_read   = grant_any & sel_rd & ~sel_wr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        read_done  = 1'b0;
        read_abort = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sel_read) state_next = WAIT_READ;
            end
            WAIT_READ: begin
                // Memory data takes priority over an expiring timeout.
                if (mem_data_read_valid) begin
                    read_done  = 1'b1;
                    state_next = IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    read_abort = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_reg       <= 1'b1;
            owner_reg            <= 1'b0;
            cnt_reg              <= '0;
            mem_addr             <= '0;
            mem_data_write       <= '0;
            mem_wr_en            <= 1'b0;
            mem_rd_en            <= 1'b0;
            req0_data_read       <= '0;
            req1_data_read       <= '0;
            req0_data_read_valid <= 1'b0;
            req1_data_read_valid <= 1'b0;
            err_timeout          <= 1'b0;
            err_sticky           <= 1'b0;
        end else begin
            mem_wr_en            <= 1'b0;
            mem_rd_en            <= 1'b0;
            req0_data_read_valid <= 1'b0;
            req1_data_read_valid <= 1'b0;
            err_timeout          <= 1'b0;

            if (grant_any) begin
                mem_addr       <= sel_addr;
                mem_data_write <= sel_data;
                mem_wr_en      <= sel_wr;
                mem_rd_en      <= sel_rd & ~sel_wr;
                last_grant_reg <= grant1;
            end

            if (sel_read) begin
                owner_reg <= grant1;
                cnt_reg   <= '0;
            end else if (state_reg == WAIT_READ) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end

            // An aborted read still completes towards its owner, with zero data.
            if (read_done || read_abort) begin
                if (owner_reg) begin
                    req1_data_read       <= read_done ? mem_data_read : '0;
                    req1_data_read_valid <= 1'b1;
                end else begin
                    req0_data_read       <= read_done ? mem_data_read : '0;
                    req0_data_read_valid <= 1'b1;
                end
            end

            if (read_abort) begin
                err_timeout <= 1'b1;
                err_sticky  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus a randomized run checked
// against a cycle-numbered transaction model of the arbitration rules.
`timescale 1ns/1ps
module tb_ram_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 16;
    localparam int RT     = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic              req0_wr_en, req0_rd_en, req1_wr_en, req1_rd_en;
    logic [DATA_W-1:0] req0_data_write, req1_data_write;
    logic              req0_ready, req1_ready;
    logic [DATA_W-1:0] req0_data_read, req1_data_read;
    logic              req0_data_read_valid, req1_data_read_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en, mem_rd_en;
    logic [DATA_W-1:0] mem_data_write, mem_data_read;
    logic              mem_data_read_valid;
    logic              err_timeout, err_sticky;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_TIMEOUT(RT)) dut (
        .clk(clk), .reset(reset),
        .req0_addr(req0_addr), .req0_wr_en(req0_wr_en), .req0_rd_en(req0_rd_en),
        .req0_data_write(req0_data_write), .req0_ready(req0_ready),
        .req0_data_read(req0_data_read), .req0_data_read_valid(req0_data_read_valid),
        .req1_addr(req1_addr), .req1_wr_en(req1_wr_en), .req1_rd_en(req1_rd_en),
        .req1_data_write(req1_data_write), .req1_ready(req1_ready),
        .req1_data_read(req1_data_read), .req1_data_read_valid(req1_data_read_valid),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_data_write(mem_data_write), .mem_data_read(mem_data_read),
        .mem_data_read_valid(mem_data_read_valid),
        .err_timeout(err_timeout), .err_sticky(err_sticky)
    );

    // ---------------- reference model ----------------
    int                cyc = 0;
    bit                m_busy;
    int                m_owner, m_last, m_gcyc;
    logic              m_mem_wr, m_mem_rd, m_v0, m_v1, m_to, m_sticky;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data, m_d0, m_d1;
    int                exp_win;
    logic              exp_wr, exp_rd;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        exp_win = -1;
        if (!m_busy) begin
            if ((req0_wr_en | req0_rd_en) && (req1_wr_en | req1_rd_en))
                exp_win = (m_last == 0) ? 1 : 0;
            else if (req0_wr_en | req0_rd_en) exp_win = 0;
            else if (req1_wr_en | req1_rd_en) exp_win = 1;
        end
        exp_wr = (exp_win == 0) ? req0_wr_en : (exp_win == 1) ? req1_wr_en : 1'b0;
        exp_rd = ((exp_win == 0) ? req0_rd_en : (exp_win == 1) ? req1_rd_en : 1'b0) & ~exp_wr;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 0; m_owner <= 0; m_last <= 1; m_gcyc <= 0;
            m_mem_wr <= 0; m_mem_rd <= 0; m_addr <= '0; m_data <= '0;
            m_v0 <= 0; m_v1 <= 0; m_d0 <= '0; m_d1 <= '0; m_to <= 0; m_sticky <= 0;
        end else begin
            m_mem_wr <= 0; m_mem_rd <= 0; m_v0 <= 0; m_v1 <= 0; m_to <= 0;
            if (exp_win >= 0) begin
                m_mem_wr <= exp_wr;
                m_mem_rd <= exp_rd;
                m_addr   <= (exp_win == 0) ? req0_addr : req1_addr;
                m_data   <= (exp_win == 0) ? req0_data_write : req1_data_write;
                m_last   <= exp_win;
                if (exp_rd) begin
                    m_busy <= 1; m_owner <= exp_win; m_gcyc <= cyc;
                end
            end else if (m_busy) begin
                if (mem_data_read_valid) begin
                    m_busy <= 0;
                    if (m_owner == 0) begin m_v0 <= 1; m_d0 <= mem_data_read; end
                    else begin m_v1 <= 1; m_d1 <= mem_data_read; end
                end else if (cyc == m_gcyc + RT) begin
                    // granted in cycle g, abort becomes visible in g+1+RT
                    m_busy <= 0; m_to <= 1; m_sticky <= 1;
                    if (m_owner == 0) begin m_v0 <= 1; m_d0 <= '0; end
                    else begin m_v1 <= 1; m_d1 <= '0; end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic wr, input logic rd,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (p == 0) begin
            req0_wr_en = wr; req0_rd_en = rd; req0_addr = a; req0_data_write = d;
        end else begin
            req1_wr_en = wr; req1_rd_en = rd; req1_addr = a; req1_data_write = d;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_req(0, 1, 0, 32'h55, 16'h77);
        tick();
        checks++;
        if (mem_wr_en !== 1'b1) begin
            errors++; $display("FAIL reset_pre_write got=%b exp=1", mem_wr_en);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({mem_wr_en, mem_rd_en, req0_data_read_valid, req1_data_read_valid, err_timeout, err_sticky} !== 6'b0) begin
            errors++; $display("FAIL reset_flags got=%b exp=000000",
                {mem_wr_en, mem_rd_en, req0_data_read_valid, req1_data_read_valid, err_timeout, err_sticky});
        end
        checks++;
        if (mem_addr !== '0 || mem_data_write !== '0 || req0_data_read !== '0 || req1_data_read !== '0) begin
            errors++; $display("FAIL reset_data addr=%h wdata=%h rd0=%h rd1=%h exp=0",
                mem_addr, mem_data_write, req0_data_read, req1_data_read);
        end
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL reset_ready got=%b exp=10", {req0_ready, req1_ready});
        end
        set_req(0, 0, 0, '0, '0);
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        set_req(0, 1, 0, 32'h10, 16'hABCD);
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL write_ready got=%b exp=10", {req0_ready, req1_ready});
        end
        tick();
        set_req(0, 0, 0, '0, '0);
        @(negedge clk);
        checks++;
        if (mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0 || mem_addr !== 32'h10 || mem_data_write !== 16'hABCD) begin
            errors++; $display("FAIL write_cmd wr=%b rd=%b addr=%h data=%h exp wr=1 rd=0 addr=10 data=abcd",
                mem_wr_en, mem_rd_en, mem_addr, mem_data_write);
        end
        tick();
        @(negedge clk);
        checks++;
        if (mem_wr_en !== 1'b0) begin
            errors++; $display("FAIL write_one_cycle got=%b exp=0", mem_wr_en);
        end
        tick();
    endtask

    task automatic test_contention();
        int w = 1;  // port 0 won the previous grant, so port 1 wins the first tie
        int prev = 0;
        set_req(0, 1, 0, 32'h100, 16'h1000);
        set_req(1, 1, 0, 32'h200, 16'h2000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) begin
                checks++;
                if ({req0_ready, req1_ready} !== ((w == 0) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL contention_grant i=%0d got=%b exp_port=%0d", i, {req0_ready, req1_ready}, w);
                end
            end
            if (i > 0) begin
                checks++;
                if (mem_wr_en !== 1'b1 || mem_addr !== ((prev == 0) ? 32'h100 : 32'h200)) begin
                    errors++; $display("FAIL contention_mem i=%0d wr=%b addr=%h exp_port=%0d", i, mem_wr_en, mem_addr, prev);
                end
            end
            prev = w;
            w = 1 - w;
            tick();
            if (i == 3) begin
                set_req(0, 0, 0, '0, '0);
                set_req(1, 0, 0, '0, '0);
            end
        end
        @(negedge clk);
        checks++;
        if (mem_wr_en !== 1'b0) begin
            errors++; $display("FAIL contention_end got=%b exp=0", mem_wr_en);
        end
        tick();
    endtask

    task automatic test_read_routing();
        set_req(1, 0, 1, 32'h20, '0);
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++; $display("FAIL route_grant got=%b exp=01", {req0_ready, req1_ready});
        end
        tick();
        set_req(1, 0, 0, '0, '0);
        set_req(0, 1, 0, 32'h300, 16'h3333);
        for (int c = 1; c <= 5; c++) begin
            if (c == 4) begin mem_data_read_valid = 1'b1; mem_data_read = 16'h1234; end
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (mem_rd_en !== 1'b1 || mem_wr_en !== 1'b0 || mem_addr !== 32'h20) begin
                    errors++; $display("FAIL route_cmd rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=20", mem_rd_en, mem_wr_en, mem_addr);
                end
            end
            if (c <= 4) begin
                checks++;
                if ({req0_ready, req1_ready, req0_data_read_valid, req1_data_read_valid} !== 4'b0) begin
                    errors++; $display("FAIL route_wait c=%0d got=%b exp=0000", c,
                        {req0_ready, req1_ready, req0_data_read_valid, req1_data_read_valid});
                end
            end else begin
                checks++;
                if (req1_data_read_valid !== 1'b1 || req1_data_read !== 16'h1234 || req0_data_read_valid !== 1'b0) begin
                    errors++; $display("FAIL route_return v1=%b d1=%h v0=%b exp v1=1 d1=1234 v0=0",
                        req1_data_read_valid, req1_data_read, req0_data_read_valid);
                end
                checks++;
                if (err_timeout !== 1'b0 || err_sticky !== 1'b0 || req0_ready !== 1'b1) begin
                    errors++; $display("FAIL route_after to=%b sticky=%b ready0=%b exp 0 0 1", err_timeout, err_sticky, req0_ready);
                end
            end
            tick();
            mem_data_read_valid = 1'b0;
        end
        set_req(0, 0, 0, '0, '0);
        tick();
    endtask

    task automatic test_timeout();
        set_req(0, 0, 1, 32'h40, '0);
        tick();
        set_req(0, 0, 0, '0, '0);
        mem_data_read_valid = 1'b1; mem_data_read = 16'h5A5A;
        tick();
        mem_data_read_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req0_data_read_valid !== 1'b1 || req0_data_read !== 16'h5A5A) begin
            errors++; $display("FAIL timeout_preload v0=%b d0=%h exp 1 5a5a", req0_data_read_valid, req0_data_read);
        end
        tick();
        set_req(0, 0, 1, 32'h30, '0);
        tick();
        set_req(0, 0, 0, '0, '0);
        set_req(1, 1, 0, 32'h400, 16'h4444);
        for (int c = 1; c <= 7; c++) begin
            if (c == 6) begin mem_data_read_valid = 1'b1; mem_data_read = 16'h9999; end
            @(negedge clk);
            if (c <= 4) begin
                checks++;
                if ({req0_data_read_valid, err_timeout, req1_ready} !== 3'b0) begin
                    errors++; $display("FAIL timeout_wait c=%0d got=%b exp=000", c, {req0_data_read_valid, err_timeout, req1_ready});
                end
            end else if (c == 5) begin
                checks++;
                if (req0_data_read_valid !== 1'b1 || req0_data_read !== '0 || err_timeout !== 1'b1 || err_sticky !== 1'b1) begin
                    errors++; $display("FAIL timeout_abort v0=%b d0=%h to=%b sticky=%b exp 1 0 1 1",
                        req0_data_read_valid, req0_data_read, err_timeout, err_sticky);
                end
            end else begin
                checks++;
                if ({req0_data_read_valid, req1_data_read_valid, err_timeout, err_sticky} !== 4'b0001 || req0_data_read !== '0) begin
                    errors++; $display("FAIL timeout_after c=%0d got=%b d0=%h exp=0001 d0=0", c,
                        {req0_data_read_valid, req1_data_read_valid, err_timeout, err_sticky}, req0_data_read);
                end
            end
            tick();
            mem_data_read_valid = 1'b0;
            if (c == 5) set_req(1, 0, 0, '0, '0);
        end
    endtask

    task automatic test_reset_mid_read();
        set_req(1, 0, 1, 32'h50, '0);
        tick();
        set_req(1, 0, 0, '0, '0);
        @(negedge clk);
        checks++;
        if (mem_rd_en !== 1'b1) begin
            errors++; $display("FAIL midreset_issue got=%b exp=1", mem_rd_en);
        end
        tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({req0_data_read_valid, req1_data_read_valid, err_timeout, err_sticky, mem_rd_en, mem_wr_en} !== 6'b0) begin
            errors++; $display("FAIL midreset_clear got=%b exp=000000",
                {req0_data_read_valid, req1_data_read_valid, err_timeout, err_sticky, mem_rd_en, mem_wr_en});
        end
        tick();
        reset = 1'b0;
        mem_data_read_valid = 1'b1; mem_data_read = 16'hDEAD;
        set_req(1, 1, 0, 32'h60, 16'h6666);
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_regrant got=%b exp=1", req1_ready);
        end
        tick();
        mem_data_read_valid = 1'b0;
        set_req(1, 0, 0, '0, '0);
        @(negedge clk);
        checks++;
        if (req0_data_read_valid !== 1'b0 || req1_data_read_valid !== 1'b0 || mem_wr_en !== 1'b1 || mem_addr !== 32'h60) begin
            errors++; $display("FAIL midreset_after v0=%b v1=%b wr=%b addr=%h exp 0 0 1 60",
                req0_data_read_valid, req1_data_read_valid, mem_wr_en, mem_addr);
        end
        tick();
    endtask

    task automatic test_random();
        bit pend0 = 0, pend1 = 0, g0, g1;
        int k;
        for (int c = 0; c < 600; c++) begin
            if (!pend0 && $urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, 2);
                set_req(0, k != 1, k != 0, $urandom, DATA_W'($urandom));
                pend0 = 1;
            end
            if (!pend1 && $urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, 2);
                set_req(1, k != 1, k != 0, $urandom, DATA_W'($urandom));
                pend1 = 1;
            end
            mem_data_read_valid = ($urandom_range(0, 3) == 0);
            mem_data_read = DATA_W'($urandom);
            @(negedge clk);
            checks++;
            if ({req0_ready, req1_ready, mem_wr_en, mem_rd_en, req0_data_read_valid, req1_data_read_valid, err_timeout, err_sticky}
                !== {exp_win == 0, exp_win == 1, m_mem_wr, m_mem_rd, m_v0, m_v1, m_to, m_sticky}) begin
                errors++; $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", c,
                    {req0_ready, req1_ready, mem_wr_en, mem_rd_en, req0_data_read_valid, req1_data_read_valid, err_timeout, err_sticky},
                    {exp_win == 0, exp_win == 1, m_mem_wr, m_mem_rd, m_v0, m_v1, m_to, m_sticky});
            end
            if (m_mem_wr | m_mem_rd) begin
                checks++;
                if (mem_addr !== m_addr) begin
                    errors++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", c, mem_addr, m_addr);
                end
            end
            if (m_mem_wr) begin
                checks++;
                if (mem_data_write !== m_data) begin
                    errors++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", c, mem_data_write, m_data);
                end
            end
            checks++;
            if (req0_data_read !== m_d0 || req1_data_read !== m_d1) begin
                errors++; $display("FAIL rnd_rdata cyc=%0d got=%h/%h exp=%h/%h", c, req0_data_read, req1_data_read, m_d0, m_d1);
            end
            g0 = req0_ready;
            g1 = req1_ready;
            tick();
            if (g0) begin set_req(0, 0, 0, '0, '0); pend0 = 0; end
            if (g1) begin set_req(1, 0, 0, '0, '0); pend1 = 0; end
        end
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        mem_data_read_valid = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        mem_data_read = '0;
        mem_data_read_valid = 1'b0;
        #2 reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        test_reset();
        test_single_write();
        test_contention();
        test_read_routing();
        test_timeout();
        test_reset_mid_read();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
